// File: rtl/im_iw_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_iw_stage_pkg
// Brief    : Shared memory-op encodings, size decode and data memory defaults
//            for the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package im_iw_stage_pkg;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_HU = 3'b010;
    localparam logic [2:0] MEMOP_B  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;

    typedef enum logic [1:0] {
        SIZE_W = 2'd0,
        SIZE_H = 2'd1,
        SIZE_B = 2'd2
    } mem_size_e;

    localparam int DM_WORDS_DEFAULT = 3072;
    localparam int DM_AW_DEFAULT    = 12;

    // Unused encodings fall back to word size.
    function automatic mem_size_e memop_size(input logic [2:0] op);
        case (op)
            MEMOP_H, MEMOP_HU: memop_size = SIZE_H;
            MEMOP_B, MEMOP_BU: memop_size = SIZE_B;
            default:           memop_size = SIZE_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/im_iw_stage_dm_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : dm_load_ext
// Brief    : Lane select and sign/zero extension of a raw 32-bit memory word.
// Revision : 1.0 - initial release
// ============================================================================
module dm_load_ext
    import im_iw_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_memop,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        case (i_memop)
            MEMOP_H:  o_data = {{16{w_half[15]}}, w_half};
            MEMOP_HU: o_data = {16'h0000, w_half};
            MEMOP_B:  o_data = {{24{w_byte[7]}}, w_byte};
            MEMOP_BU: o_data = {24'h000000, w_byte};
            default:  o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/im_iw_stage.sv
`default_nettype none
// ============================================================================
// Module   : im_iw_stage
// Brief    : Memory stage (data memory, store merge, load extension) plus the
//            MEM/WB pipeline register. Optional macro DM_WRITE_LOG_EN prints
//            every performed store.
// Revision : 1.0 - initial release
// ============================================================================
module im_iw_stage
    import im_iw_stage_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int DM_AW    = DM_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [2:0]  MemOpM,
    input  logic [31:0] AOE,
    input  logic [31:0] WDE,
    input  logic [4:0]  WAE,
    input  logic [31:0] PCE,
    input  logic        StallW,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic [31:0] RDW,
    output logic [31:0] AOW,
    output logic [4:0]  WAW,
    output logic [31:0] PCW,
    output logic        MisalignW
);

    logic [31:0]      r_mem [DM_WORDS];
    logic [DM_AW-1:0] w_idx;
    logic             w_in_range;
    logic [31:0]      w_rword;
    mem_size_e        w_size;
    logic             w_misalign;
    logic [3:0]       w_be;
    logic [31:0]      w_lanes;
    logic [31:0]      w_merged;
    logic             w_do_write;
    logic [31:0]      w_load_data;

    assign w_idx      = AOE[DM_AW+1:2];
    assign w_in_range = ({1'b0, w_idx} < (DM_AW+1)'(DM_WORDS));
    assign w_rword    = w_in_range ? r_mem[w_idx] : 32'h0;
    assign w_size     = memop_size(MemOpM);

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_lanes    = WDE;
        case (w_size)
            SIZE_H: begin
                w_misalign = AOE[0];
                w_be       = AOE[1] ? 4'b1100 : 4'b0011;
                w_lanes    = {2{WDE[15:0]}};
            end
            SIZE_B: begin
                w_be    = 4'b0001 << AOE[1:0];
                w_lanes = {4{WDE[7:0]}};
            end
            default: begin
                w_misalign = (AOE[1:0] != 2'b00);
            end
        endcase
    end

    // Read-modify-write: unaddressed lanes keep the current array contents.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_merged[8*i +: 8] = w_be[i] ? w_lanes[8*i +: 8] : w_rword[8*i +: 8];
    end

    assign w_do_write = MemWriteM && !w_misalign && w_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_do_write) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && w_do_write) begin
            $display("%d@%h: *%h <= %h", $time, PCE, {AOE[31:2], 2'b00}, w_merged);
        end
    end
`else
`endif

    dm_load_ext u_load_ext (
        .i_word    (w_rword),
        .i_addr_lo (AOE[1:0]),
        .i_memop   (MemOpM),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            MemtoRegW <= 1'b0;
            RegWriteW <= 1'b0;
            RDW       <= 32'h0;
            AOW       <= 32'h0;
            WAW       <= 5'd0;
            PCW       <= 32'h0;
            MisalignW <= 1'b0;
        end else if (!StallW) begin
            MemtoRegW <= MemtoRegM;
            RegWriteW <= RegWriteM && !(MemtoRegM && w_misalign);
            RDW       <= w_load_data;
            AOW       <= AOE;
            WAW       <= WAE;
            PCW       <= PCE;
            MisalignW <= (MemWriteM || MemtoRegM) && w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_iw_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_iw_stage
// Brief    : Scoreboard bench for im_iw_stage with directed memory vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_iw_stage;
    import im_iw_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, RegWriteM, MemWriteM, StallW;
    logic [2:0]  MemOpM;
    logic [31:0] AOE, WDE, PCE;
    logic [4:0]  WAE;
    logic        MemtoRegW, RegWriteW, MisalignW;
    logic [31:0] RDW, AOW, PCW;
    logic [4:0]  WAW;

    always #5 clk = ~clk;

    im_iw_stage dut (
        .clk       (clk),
        .reset     (reset),
        .MemtoRegM (MemtoRegM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM),
        .MemOpM    (MemOpM),
        .AOE       (AOE),
        .WDE       (WDE),
        .WAE       (WAE),
        .PCE       (PCE),
        .StallW    (StallW),
        .MemtoRegW (MemtoRegW),
        .RegWriteW (RegWriteW),
        .RDW       (RDW),
        .AOW       (AOW),
        .WAW       (WAW),
        .PCW       (PCW),
        .MisalignW (MisalignW)
    );

    typedef struct {
        int          due;
        logic        m2r;
        logic        rw;
        logic        mis;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] ao;
        logic [31:0] pc;
        logic [4:0]  wa;
    } exp_t;

    exp_t        q[$];
    exp_t        r_last;
    exp_t        r_mon;
    int          r_cyc  = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    logic [31:0] r_pc   = 32'h0000_1000;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, r_cyc, act, req);
        end
    endtask

    // Monitor: compare W outputs against the entry due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= r_cyc) begin
            r_mon = q.pop_front();
            chk("MemtoRegW", {31'h0, MemtoRegW}, {31'h0, r_mon.m2r});
            chk("RegWriteW", {31'h0, RegWriteW}, {31'h0, r_mon.rw});
            chk("MisalignW", {31'h0, MisalignW}, {31'h0, r_mon.mis});
            chk("AOW", AOW, r_mon.ao);
            chk("WAW", {27'h0, WAW}, {27'h0, r_mon.wa});
            chk("PCW", PCW, r_mon.pc);
            if (r_mon.chk_rd) chk("RDW", RDW, r_mon.rd);
        end
    end

    task automatic drive(input logic rst, input logic stall, input logic m2r, input logic rw,
                         input logic mw, input logic [2:0] op, input logic [31:0] ao,
                         input logic [31:0] wd, input logic [4:0] wa);
        @(posedge clk);
        #1;
        reset     = rst;
        StallW    = stall;
        MemtoRegM = m2r;
        RegWriteM = rw;
        MemWriteM = mw;
        MemOpM    = op;
        AOE       = ao;
        WDE       = wd;
        WAE       = wa;
        PCE       = r_pc;
        r_pc      = r_pc + 32'd4;
    endtask

    task automatic issue(input logic m2r, input logic rw, input logic mw, input logic [2:0] op,
                         input logic [31:0] ao, input logic [31:0] wd, input logic [4:0] wa,
                         input logic chk_rd, input logic [31:0] exp_rd,
                         input logic exp_rw, input logic exp_mis);
        exp_t e;
        drive(1'b0, 1'b0, m2r, rw, mw, op, ao, wd, wa);
        e.due = r_cyc + 1; e.m2r = m2r; e.rw = exp_rw; e.mis = exp_mis;
        e.chk_rd = chk_rd; e.rd = exp_rd; e.ao = ao; e.pc = PCE; e.wa = wa;
        r_last = e;
        q.push_back(e);
    endtask

    task automatic stall_issue(input logic m2r, input logic rw, input logic mw, input logic [2:0] op,
                               input logic [31:0] ao, input logic [31:0] wd, input logic [4:0] wa);
        exp_t e;
        drive(1'b0, 1'b1, m2r, rw, mw, op, ao, wd, wa);
        e = r_last;
        e.due = r_cyc + 1;
        q.push_back(e);
    endtask

    task automatic rst_cycle(input logic mw, input logic [31:0] ao, input logic [31:0] wd);
        exp_t e;
        drive(1'b1, 1'b1, 1'b1, 1'b1, mw, MEMOP_W, ao, wd, 5'd9);
        e.due = r_cyc + 1; e.m2r = 1'b0; e.rw = 1'b0; e.mis = 1'b0;
        e.chk_rd = 1'b1; e.rd = 32'h0; e.ao = 32'h0; e.pc = 32'h0; e.wa = 5'd0;
        r_last = e;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; StallW = 1'b0; MemtoRegM = 1'b0; RegWriteM = 1'b0; MemWriteM = 1'b0;
        MemOpM = MEMOP_W; AOE = '0; WDE = '0; WAE = '0; PCE = '0;

        rst_cycle(1'b0, 32'h0, 32'h0);
        rst_cycle(1'b0, 32'h0, 32'h0);

        //    m2r rw mw  op        ao            wd            wa  chk exp_rd        rw mis
        issue(0, 0, 1, MEMOP_W,  32'h10,   32'h12345678, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_W,  32'h10,   32'h0,        5'd5, 1, 32'h12345678,  1, 0);
        issue(0, 0, 1, MEMOP_B,  32'h13,   32'h123456AB, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_W,  32'h10,   32'h0,        5'd6, 1, 32'hAB345678,  1, 0);
        issue(1, 1, 0, MEMOP_B,  32'h13,   32'h0,        5'd6, 1, 32'hFFFFFFAB,  1, 0);
        issue(1, 1, 0, MEMOP_BU, 32'h13,   32'h0,        5'd6, 1, 32'h000000AB,  1, 0);
        issue(0, 0, 1, MEMOP_H,  32'h12,   32'hCAFE8001, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_H,  32'h12,   32'h0,        5'd7, 1, 32'hFFFF8001,  1, 0);
        issue(1, 1, 0, MEMOP_HU, 32'h12,   32'h0,        5'd7, 1, 32'h00008001,  1, 0);
        issue(1, 1, 0, MEMOP_HU, 32'h10,   32'h0,        5'd7, 1, 32'h00005678,  1, 0);
        // Misaligned stores are suppressed and flagged.
        issue(0, 0, 1, MEMOP_W,  32'h11,   32'hDEADBEEF, 5'd0, 0, 32'h0,         0, 1);
        issue(0, 0, 1, MEMOP_H,  32'h11,   32'hDEADBEEF, 5'd0, 0, 32'h0,         0, 1);
        issue(1, 1, 0, MEMOP_W,  32'h10,   32'h0,        5'd8, 1, 32'h80015678,  1, 0);
        issue(1, 1, 0, MEMOP_W,  32'h12,   32'h0,        5'd8, 0, 32'h0,         0, 1);
        issue(0, 1, 0, MEMOP_W,  32'h13,   32'h0,        5'd3, 0, 32'h0,         1, 0);
        // Stall: W holds while a concurrent store still lands.
        issue(1, 1, 0, MEMOP_W,  32'h10,   32'h0,        5'd7, 1, 32'h80015678,  1, 0);
        stall_issue(0, 0, 1, MEMOP_W, 32'h24, 32'h11112222, 5'd1);
        stall_issue(1, 1, 0, MEMOP_B, 32'h13, 32'h0,        5'd2);
        issue(1, 1, 0, MEMOP_W,  32'h24,   32'h0,        5'd4, 1, 32'h11112222,  1, 0);
        // Mid-stream reset overrides a store in the same edge and clears memory.
        issue(0, 0, 1, MEMOP_W,  32'h20,   32'h77777777, 5'd0, 0, 32'h0,         0, 0);
        rst_cycle(1'b1, 32'h20, 32'h99999999);
        issue(1, 1, 0, MEMOP_W,  32'h20,   32'h0,        5'd5, 1, 32'h0,         1, 0);
        issue(1, 1, 0, MEMOP_W,  32'h24,   32'h0,        5'd5, 1, 32'h0,         1, 0);
        issue(1, 1, 0, MEMOP_W,  32'h10,   32'h0,        5'd5, 1, 32'h0,         1, 0);
        // Index wrap, out-of-range drop, and the last valid word.
        issue(0, 0, 1, MEMOP_W,  32'h10,   32'hA5A5A5A5, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_W,  32'h4010, 32'h0,        5'd6, 1, 32'hA5A5A5A5,  1, 0);
        issue(0, 0, 1, MEMOP_W,  32'h3000, 32'h5A5A5A5A, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_W,  32'h3000, 32'h0,        5'd6, 1, 32'h0,         1, 0);
        issue(1, 1, 0, MEMOP_W,  32'h0,    32'h0,        5'd6, 1, 32'h0,         1, 0);
        issue(0, 0, 1, MEMOP_W,  32'h2FFC, 32'h0BADF00D, 5'd0, 0, 32'h0,         0, 0);
        issue(1, 1, 0, MEMOP_W,  32'h2FFC, 32'h0,        5'd6, 1, 32'h0BADF00D,  1, 0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MEMOP_W, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
